// File: rtl/viterbi_link_sequencer.sv
// Test-frame controller for an encoder -> channel -> Viterbi decoder link: PRBS source,
// burst error-mask generator and latency-aligned residual bit-error checker.
module viterbi_link_sequencer #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned FLUSH_LEN = 64,
  parameter int unsigned DEC_LAT   = 40,
  parameter int unsigned N         = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        err_en_i,
  input  logic [3:0]  burst_len_i,
  output logic        enc_bit_o,
  output logic        enc_en_o,
  output logic [1:0]  err_mask_o,
  input  logic        dec_bit_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] inj_ct_o,
  output logic [15:0] bit_err_ct_o
);

  localparam int unsigned PERIOD     = 1 << N;
  localparam logic [31:0] RUN_LAST   = 32'(FRAME_LEN - 1);
  localparam logic [31:0] FLUSH_LAST = 32'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state;
  logic [31:0]        cnt;
  logic [31:0]        cnt_inc;
  logic [15:0]        lfsr;
  logic [DEC_LAT-1:0] dl_bit;
  logic [DEC_LAT-1:0] dl_val;
  logic [8:0]         burst_clamped;
  logic               cmp_err;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // The last burst_clamped words of every 2**N-word period carry an error.
  function automatic logic [1:0] mask_for(input logic [N-1:0] kmod, input logic en,
                                          input logic [8:0] burst);
    logic hit;
    hit = en && (burst != 9'd0) && (9'(kmod) >= (9'(PERIOD) - burst));
    return {1'b0, hit};
  endfunction

  always_comb begin
    cnt_inc       = cnt + 32'd1;
    burst_clamped = ({5'd0, burst_len_i} > 9'(PERIOD)) ? 9'(PERIOD) : {5'd0, burst_len_i};
    cmp_err       = ((state == RUN) || (state == FLUSH)) && dl_val[DEC_LAT-1] &&
                    (dec_bit_i != dl_bit[DEC_LAT-1]);
  end

  // Outputs are computed one edge ahead so that they are valid in the cycle they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lfsr         <= SEED;
      dl_bit       <= '0;
      dl_val       <= '0;
      enc_bit_o    <= 1'b0;
      enc_en_o     <= 1'b0;
      err_mask_o   <= 2'b00;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      inj_ct_o     <= '0;
      bit_err_ct_o <= '0;
    end else begin
      done_o <= 1'b0;
      if ((state == RUN) || (state == FLUSH)) begin
        dl_bit <= (dl_bit << 1) | DEC_LAT'(enc_bit_o);
        dl_val <= (dl_val << 1) | DEC_LAT'(state == RUN);
        if (cmp_err && (bit_err_ct_o != 16'hFFFF))
          bit_err_ct_o <= bit_err_ct_o + 16'd1;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state        <= RUN;
            cnt          <= '0;
            lfsr         <= lfsr_step(SEED);
            dl_bit       <= '0;
            dl_val       <= '0;
            enc_bit_o    <= SEED[0];
            enc_en_o     <= 1'b1;
            busy_o       <= 1'b1;
            err_mask_o   <= mask_for('0, err_en_i, burst_clamped);
            inj_ct_o     <= '0;
            bit_err_ct_o <= '0;
          end
        end
        RUN: begin
          if ((err_mask_o != 2'b00) && (inj_ct_o != 16'hFFFF))
            inj_ct_o <= inj_ct_o + 16'd1;
          if (cnt == RUN_LAST) begin
            state      <= FLUSH;
            cnt        <= '0;
            enc_bit_o  <= 1'b0;
            err_mask_o <= 2'b00;
          end else begin
            cnt        <= cnt_inc;
            enc_bit_o  <= lfsr[0];
            lfsr       <= lfsr_step(lfsr);
            err_mask_o <= mask_for(cnt_inc[N-1:0], err_en_i, burst_clamped);
          end
        end
        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state    <= DONE;
            cnt      <= '0;
            enc_en_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/viterbi_link_sequencer.md
Name: viterbi_link_sequencer

Overview:
Test-frame controller for the convolutional encoder -> channel -> Viterbi decoder link. On a start pulse it drives a PRBS bit stream and encoder enable for one frame, then appends tail (flush) bits. It generates the channel error-injection mask on a programmable burst schedule. It compares decoder output against the latency-aligned source bits and reports injected-error and residual-bit-error counts.

Parameters:
FRAME_LEN, 256, data bits per frame (2..65535)
FLUSH_LEN, 64, zero tail bits after the frame; must be >= DEC_LAT
DEC_LAT, 40, decoder latency in cycles from encoder input bit to matching dec_bit_i (1..FLUSH_LEN)
N, 4, log2 of the error-burst period (1..8)
SEED, 16'hACE1, LFSR load value; must be nonzero

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
start_i  in  1  frame start request; sampled only in IDLE
err_en_i  in  1  enables error injection; sampled each RUN cycle
burst_len_i  in  4  errored words per 2**N-word period; 0 = none; values > 2**N clamp to 2**N
enc_bit_o  out  1  bit to encoder d_in
enc_en_o  out  1  encoder enable
err_mask_o  out  2  XOR mask applied by the channel to the encoder output pair
dec_bit_i  in  1  decoder d_out
busy_o  out  1  high in RUN and FLUSH
done_o  out  1  one-cycle pulse at frame end
inj_ct_o  out  16  words with nonzero mask this frame
bit_err_ct_o  out  16  mismatching decoded bits this frame

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; enc_bit_o, enc_en_o, busy_o, done_o=0; err_mask_o=2'b00; both counters=0; LFSR=SEED; delay line cleared. Reset mid-frame aborts the frame immediately. No partial done_o is produced.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN when start_i=1. That edge loads LFSR=SEED, word counter w=0 and both counters=0.
  - RUN lasts exactly FRAME_LEN cycles, then goes to FLUSH.
  - FLUSH lasts exactly FLUSH_LEN cycles, then goes to DONE.
  - DONE lasts 1 cycle, then goes to IDLE.
  - start_i is ignored outside IDLE.
- All outputs are registered. The first RUN cycle, R0, is the cycle after start_i was sampled.
- RUN cycle k (k=0..FRAME_LEN-1):
  - enc_en_o=1 and enc_bit_o=LFSR[0].
  - LFSR advances once per RUN cycle: 16-bit Fibonacci, taps 16,14,13,11, shifting right, feedback into bit 15.
  - err_mask_o=2'b01 when err_en_i=1, burst_len_i!=0 and (k mod 2**N) >= 2**N - burst_len_i. Otherwise err_mask_o=2'b00.
  - The mask is aligned to the same cycle as enc_bit_o.
- FLUSH: enc_en_o=1, enc_bit_o=0, err_mask_o=2'b00.
- IDLE and DONE: enc_en_o=0, enc_bit_o=0, err_mask_o=2'b00.
- inj_ct_o increments on every RUN cycle with nonzero mask.
- Source-bit delay line: each driven data bit enters a DEC_LAT-deep shift register.
- Compare: at edge R0+k+DEC_LAT, for k<FRAME_LEN only, dec_bit_i is compared with bit k. Each mismatch increments bit_err_ct_o. Tail bits are never compared. All compares complete inside FLUSH.
- Both counters saturate at 16'hFFFF.
- Both counters hold their values after DONE until the next accepted start.
- done_o=1 only during the DONE cycle. busy_o=0 in DONE.
- Back-to-back frames: a start_i held high through DONE is accepted in the following IDLE cycle. The minimum inter-frame gap is 1 IDLE cycle.

Test Plan:
1. Loopback with defaults: decoder model is a DEC_LAT delay of enc_bit_o, err_en_i=0, one start pulse.
   Required: enc_en_o high for exactly 320 cycles, first enc_bit_o = SEED[0]=1, done_o pulse at R0+320, inj_ct_o=0, bit_err_ct_o=0.
2. Injection schedule: err_en_i=1, burst_len_i=1, N=4.
   Required: mask 2'b01 at k=15,31,...,255, inj_ct_o=16.
   Repeat with burst_len_i=3: mask at k mod 16 in {13,14,15}, inj_ct_o=48.
   Repeat with burst_len_i=15: inj_ct_o=240.
3. Compare path: loopback model inverts decoded bits k=10 and k=255; also flip one tail bit.
   Required: bit_err_ct_o=2 (tail flip not counted).
4. Reset mid-operation: assert rst for 1 cycle at R0+100.
   Required: next cycle enc_en_o=0, busy_o=0, counters=0, no done_o.
   A new start then reproduces scenario 1's bit sequence exactly.
5. Start handling: pulse start_i at R0+50 during RUN, then hold start_i high through DONE.
   Required: the mid-frame pulse is ignored (frame length unchanged). A second frame begins 2 cycles after done_o, with counters cleared at its start.
6. Clamp and saturation: burst_len_i=15 with N=2.
   Required: every word masked, inj_ct_o=256.
   Separately, with FRAME_LEN=65535 and an always-mismatching model: bit_err_ct_o=16'hFFFF, no wrap.
